// File: rtl/if_id_queue_pkg.sv
// Shared constants and types for the fetch/decode instruction queue.
// Fetch, decode and the hazard unit take the queue depth from here so they agree.
package if_id_queue_pkg;

  localparam int IFQ_ADDR_WIDTH = 32;
  localparam int IFQ_INST_WIDTH = 32;
  localparam int IFQ_DEPTH      = 4;

  localparam logic [IFQ_INST_WIDTH-1:0] IFQ_ZERO_WORD = '0;

  // Handshake activity in one cycle, encoded as {push, pop}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } ifq_op_e;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID queue.
interface if_id_queue_if #(
  parameter int ADDR_WIDTH = if_id_queue_pkg::IFQ_ADDR_WIDTH,
  parameter int INST_WIDTH = if_id_queue_pkg::IFQ_INST_WIDTH,
  parameter int DEPTH      = if_id_queue_pkg::IFQ_DEPTH,
  localparam int PTR_WIDTH = $clog2(DEPTH)
);

  // Valid/ready: a word moves when valid and ready are both high at a rising
  // edge; the producer keeps valid and its data stable until that happens.
  logic                  flush;
  logic                  ifValid;
  logic                  ifReady;
  logic [ADDR_WIDTH-1:0] ifPC;
  logic [INST_WIDTH-1:0] ifInst;
  logic                  idValid;
  logic                  idReady;
  logic [ADDR_WIDTH-1:0] idPC;
  logic [INST_WIDTH-1:0] idInst;
  logic [PTR_WIDTH:0]    count;

  modport master (
    output flush, ifValid, ifPC, ifInst, idReady,
    input  ifReady, idValid, idPC, idInst, count
  );

  modport slave (
    input  flush, ifValid, ifPC, ifInst, idReady,
    output ifReady, idValid, idPC, idInst, count
  );

endinterface

// File: rtl/if_id_queue_ram.sv
// Queue storage: synchronous write, asynchronous read, no reset.
module if_id_queue_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// First-word-fall-through queue of {PC, instruction} pairs between fetch and decode.
// Empty queue presents a zero bubble; flush drops everything on a redirect.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = IFQ_ADDR_WIDTH,
  parameter int INST_WIDTH = IFQ_INST_WIDTH,
  parameter int DEPTH      = IFQ_DEPTH,
  localparam int PTR_WIDTH = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          rst,
  if_id_queue_if.slave bus
);

  localparam int ENTRY_W = ADDR_WIDTH + INST_WIDTH;
  localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(DEPTH);

  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0]   count_q, count_d;
  logic                 if_ready;
  logic                 id_valid;
  logic                 push;
  logic                 pop;
  ifq_op_e              op;
  logic [ENTRY_W-1:0]   head;

  // Both ready and valid come from registered occupancy only, so idReady
  // never reaches ifReady combinationally.
  assign if_ready = (count_q != FULL_CNT);
  assign id_valid = (count_q != '0);
  assign push     = bus.ifValid & if_ready & ~bus.flush;
  assign pop      = id_valid & bus.idReady & ~bus.flush;
  assign op       = ifq_op_e'({push, pop});

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
        end
        OP_POP: begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          count_d  = count_q - 1'b1;
        end
        OP_BOTH: begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  if_id_queue_ram #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({bus.ifPC, bus.ifInst}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign bus.ifReady = if_ready;
  assign bus.idValid = id_valid;
  assign bus.idPC    = id_valid ? head[ENTRY_W-1:INST_WIDTH] : '0;
  assign bus.idInst  = id_valid ? head[INST_WIDTH-1:0] : INST_WIDTH'(IFQ_ZERO_WORD);
  assign bus.count   = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios with literal
// expectations plus a random phase, all compared against a queue-based model.
module tb_if_id_queue;

  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int W     = AW + IW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];

  if_id_queue_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH)) bus ();

  if_id_queue #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Occupancy is the queue size; the head is the oldest accepted pair.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      bit do_push, do_pop;
      do_push = bus.ifValid && (exp_q.size() < DEPTH) && !bus.flush;
      do_pop  = (exp_q.size() > 0) && bus.idReady && !bus.flush;
      if (bus.flush) exp_q.delete();
      else begin
        if (do_pop)  void'(exp_q.pop_front());
        if (do_push) exp_q.push_back({bus.ifPC, bus.ifInst});
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [W-1:0] head;
    int sz;
    sz   = exp_q.size();
    head = (sz != 0) ? exp_q[0] : '0;
    chk("m_idValid", W'(bus.idValid), W'(sz != 0));
    chk("m_ifReady", W'(bus.ifReady), W'(sz != DEPTH));
    chk("m_count",   W'(bus.count),   W'(sz));
    chk("m_idPC",    W'(bus.idPC),    W'(head[W-1:IW]));
    chk("m_idInst",  W'(bus.idInst),  W'(head[IW-1:0]));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] pc, input logic [IW-1:0] inst,
                       input logic rdy, input logic fl);
    bus.ifValid = v;
    bus.ifPC    = pc;
    bus.ifInst  = inst;
    bus.idReady = rdy;
    bus.flush   = fl;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [AW-1:0] pc,
                            input logic [IW-1:0] inst, input int cnt, input logic rdy);
    chk({name, "_idValid"}, W'(bus.idValid), W'(v));
    chk({name, "_idPC"},    W'(bus.idPC),    W'(pc));
    chk({name, "_idInst"},  W'(bus.idInst),  W'(inst));
    chk({name, "_count"},   W'(bus.count),   W'(cnt));
    chk({name, "_ifReady"}, W'(bus.ifReady), W'(rdy));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [IW-1:0] stream_inst [3];
    stream_inst[0] = 32'h2001_0001;
    stream_inst[1] = 32'h2002_0002;
    stream_inst[2] = 32'h2003_0003;

    drive(1'b0, '0, '0, 1'b0, 1'b0);

    // 1. reset and idle
    repeat (2) @(posedge clk);
    #1;
    expect_out("rst_hold", 1'b0, '0, '0, 0, 1'b1);
    rst = 1'b0;
    step();
    expect_out("idle", 1'b0, '0, '0, 0, 1'b1);

    // 2. streaming with decode always ready
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, AW'(4 * i), stream_inst[i], 1'b1, 1'b0);
      step();
      expect_out("stream", 1'b1, AW'(4 * i), stream_inst[i], 1, 1'b1);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    expect_out("stream_end", 1'b0, '0, '0, 0, 1'b1);

    // 3. fill and backpressure
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(32'h10 + 4 * i), IW'(32'hA000 + i), 1'b0, 1'b0);
      step();
    end
    expect_out("full", 1'b1, 32'h10, 32'hA000, 4, 1'b0);
    drive(1'b1, 32'h20, 32'hA004, 1'b0, 1'b0);
    step();
    expect_out("full_refuse", 1'b1, 32'h10, 32'hA000, 4, 1'b0);
    bus.idReady = 1'b1;
    step();
    expect_out("drain0", 1'b1, 32'h14, 32'hA001, 3, 1'b1);
    step();
    expect_out("drain1", 1'b1, 32'h18, 32'hA002, 3, 1'b1);
    bus.ifValid = 1'b0;
    step();
    expect_out("drain2", 1'b1, 32'h1C, 32'hA003, 2, 1'b1);
    step();
    expect_out("drain3", 1'b1, 32'h20, 32'hA004, 1, 1'b1);
    step();
    expect_out("drained", 1'b0, '0, '0, 0, 1'b1);

    // 4. wrap-around with paired push/pop
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, AW'(32'h100 + 4 * i), IW'(32'hB000 + i), 1'b1, 1'b0);
      step();
      expect_out("wrap", 1'b1, AW'(32'h100 + 4 * i), IW'(32'hB000 + i), 1, 1'b1);
    end
    bus.ifValid = 1'b0;
    step();
    expect_out("wrap_end", 1'b0, '0, '0, 0, 1'b1);

    // 5. flush against simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, AW'(32'h40 + 4 * i), IW'(32'hC000 + i), 1'b0, 1'b0);
      step();
    end
    expect_out("pre_flush", 1'b1, 32'h40, 32'hC000, 3, 1'b1);
    drive(1'b1, 32'h4C, 32'hC003, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    expect_out("flush", 1'b0, '0, '0, 0, 1'b1);
    step();
    expect_out("flush_after", 1'b0, '0, '0, 0, 1'b1);

    // flush while empty
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    expect_out("flush_empty", 1'b0, '0, '0, 0, 1'b1);

    // 6. asynchronous reset mid-burst
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, AW'(32'h60 + 4 * i), IW'(32'hD000 + i), 1'b0, 1'b0);
      step();
    end
    bus.ifValid = 1'b0;
    expect_out("pre_rst", 1'b1, 32'h60, 32'hD000, 2, 1'b1);
    #2 rst = 1'b1;
    #1;
    expect_out("async_rst", 1'b0, '0, '0, 0, 1'b1);
    #2 rst = 1'b0;
    drive(1'b1, 32'h80, 32'hE000, 1'b0, 1'b0);
    step();
    bus.ifValid = 1'b0;
    expect_out("post_rst", 1'b1, 32'h80, 32'hE000, 1, 1'b1);
    bus.idReady = 1'b1;
    step();
    expect_out("post_rst_pop", 1'b0, '0, '0, 0, 1'b1);

    // random phase: fetch holds its word until accepted
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      logic acc;
      acc = bus.ifValid && bus.ifReady && !bus.flush;
      if (!bus.ifValid || acc || bus.flush) begin
        bus.ifValid = ($urandom_range(0, 3) != 0);
        bus.ifPC    = $urandom();
        bus.ifInst  = $urandom();
      end
      bus.idReady = ($urandom_range(0, 2) == 0);
      bus.flush   = ($urandom_range(0, 31) == 0);
      if (c < 1500 && ($urandom_range(0, 3) == 0)) bus.idReady = 1'b1;
      step();
    end

    drive(1'b0, '0, '0, 1'b0, 1'b0);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-register IF/ID latch: a DEPTH-entry first-word-fall-through queue of {PC, instruction} pairs between fetch and decode.
- Adds valid/ready handshakes on both sides, so fetch can run ahead while decode stalls.
- Adds a flush that discards all queued instructions on branch/jump redirect.
- Presents a zero-word bubble (NOP, PC 0) to decode whenever empty.

Parameters:
- ADDR_WIDTH, `INST_ADDR_WIDTH (32): PC width.
- INST_WIDTH, `INST_WIDTH (32): instruction width.
- DEPTH, 4: number of entries. Must be a power of two and at least 2.
- PTR_WIDTH, $clog2(DEPTH): read/write pointer width. Derived; do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all entries this cycle; from the branch/jump resolver.
- ifValid  in  1  fetch presents a valid {ifPC, ifInst}.
- ifReady  out  1  queue can accept a write this cycle.
- ifPC  in  ADDR_WIDTH  fetched PC.
- ifInst  in  INST_WIDTH  fetched instruction.
- idValid  out  1  head entry is valid.
- idReady  in  1  decode consumes the head this cycle.
- idPC  out  ADDR_WIDTH  head PC, or 0 when empty.
- idInst  out  INST_WIDTH  head instruction, or `ZERO_WORD when empty.
- count  out  PTR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, rst=1), effective immediately and independent of clk:
  - read pointer, write pointer and count go to 0;
  - idValid=0, idPC=0, idInst=0, ifReady=1.
  - Storage array contents are don't-care; reset is not required on the array.
- Deassertion of rst: the first write may occur on the first rising edge after deassertion.
- Write condition: push = ifValid & ifReady & ~flush.
  - Stores {ifPC, ifInst} at the write pointer; the write pointer increments modulo DEPTH (natural wrap).
- Read condition: pop = idValid & idReady & ~flush.
  - The read pointer increments modulo DEPTH.
- ifReady = (count != DEPTH). It depends only on registered state, with no combinational path from idReady.
  - Consequence: a full queue refuses a write even in a cycle where decode pops.
- idValid = (count != 0). idPC/idInst are read combinationally from the head entry when idValid=1, and forced to 0 when idValid=0.
- Latency: an entry written at edge N is visible on idPC/idInst/idValid after edge N and can be consumed at edge N+1. There is no same-cycle bypass from if* to id*.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged; both pointers advance.
- Full (count=DEPTH): ifReady=0 and ifValid is ignored. Fetch holds its data (standard valid/ready rule: ifValid/ifPC/ifInst stable until accepted).
- Empty (count=0): idValid=0, outputs are the zero bubble, and idReady is ignored.
- Flush at a rising edge:
  - Pointers and count go to 0.
  - Any simultaneous push and pop are suppressed; flush wins over both.
  - The next cycle shows idValid=0 and ifReady=1.
  - Flush while empty is a no-op.
- Pointer wrap: with DEPTH=4, after 4 pushes and 4 pops both pointers are back at 0. FIFO order is preserved across the wrap.
- Reset mid-operation: all in-flight entries are lost and outputs return to the reset values immediately (asynchronous).
- Invariant: 0 ≤ count ≤ DEPTH. It holds in every cycle regardless of input activity, including push while full and pop while empty.

Decomposition:
- define.v (shared):
  - `INST_ADDR_WIDTH, `INST_WIDTH, `ZERO_WORD: already present.
  - Add `IFQ_DEPTH (default 4) so fetch, decode and the hazard unit agree on depth.
- Sub-module if_id_ram:
  - DEPTH x (ADDR_WIDTH+INST_WIDTH) storage.
  - Synchronous write port; asynchronous read port addressed by the read pointer.
  - No reset.
- The top level holds pointers, count, handshake logic and output muxing.

Test Plan:
1. Reset and idle: rst=1 for 2 cycles, then 0, with no ifValid. Required: idValid=0, idInst=0, idPC=0, ifReady=1, count=0 throughout.
2. Streaming: idReady=1; push PC=0x00,0x04,0x08 with Inst=0x20010001,0x20020002,0x20030003 on consecutive edges. Required: each pair appears on id* exactly one edge after its write, in order; count stays ≤1.
3. Fill and backpressure (DEPTH=4): idReady=0; offer PCs 0x10..0x20 step 4 (5 words). Required:
   - after 4 edges, count=4 and ifReady=0;
   - the 5th word (0x20) is not accepted;
   - on raising idReady, heads drain 0x10, 0x14, 0x18, 0x1C, and 0x20 is then accepted.
4. Wrap-around: 6 push/pop pairs at DEPTH=4 with PCs 0x100..0x114. Required: output order is exactly 0x100..0x114 and count ends at 0.
5. Flush with simultaneous push/pop: count=3 (PCs 0x40,0x44,0x48); assert flush with ifValid=1 (PC 0x4C) and idReady=1. Required: next cycle count=0, idValid=0, ifReady=1, and 0x4C never appears.
6. Async reset mid-burst: count=2; assert rst between clock edges. Required: idValid=0, count=0, idInst=0 before the next rising edge; after release, push PC 0x80 and it is the head one edge later.
